deco_n_neg_scan: RTL
====================

# deco_n_neg_scan

Parametrised, registered successor to the team's 2-to-4 active-low decoder with enable. Decodes an SEL_W-bit select into 2^SEL_W active-low one-hot lines. It adds two self-timed modes: a continuous scan and a single sweep, each with a programmable dwell per line. It drives row/digit strobes and bank selects in the multiplexed-display and memory-select paths.

## Interface
- SEL_W, 2: select width; output count OUTS = 2**SEL_W (localparam), SEL_W in 1..5.
- DWELL, 4: clock cycles each line stays asserted in scan/sweep; DWELL >= 1.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- eneable  in  1  active-high enable; low forces all outputs inactive.
- mode  in  2  00 direct, 01 continuous scan, 10 single sweep, 11 reserved (treated as 00).
- a  in  SEL_W  select used in direct mode.
- start  in  1  single-cycle pulse, launches a sweep in mode 10.
- dn  out  OUTS  active-low one-hot strobes, registered.
- idx  out  SEL_W  index of the line currently driven low (0 when none).
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at sweep completion.

## Operation
- States: IDLE, DIRECT, SCAN, SWEEP. State is selected from mode each cycle, except SWEEP, which is exited only by completion, reset or eneable low.
- DIRECT (mode 00/11): dn <= ~(1 << a), idx <= a.
- SCAN (mode 01): on entry, idx <= 0 and the dwell counter clears. idx increments every DWELL cycles and wraps OUTS-1 -> 0. dn <= ~(1 << idx).
- SWEEP: entered from IDLE/DIRECT/SCAN when mode == 10 and start == 1. Drives idx 0..OUTS-1, DWELL cycles each. After the last dwell:
  - dn <= all ones, done pulses for 1 cycle, busy drops.
  - State returns to IDLE if mode is still 10, otherwise to the state mode selects.
- Mode 10 without start: IDLE, dn all ones.
- start while busy is ignored; no restart and no queueing.
- A mode change during SWEEP is ignored until completion.
- eneable low, any state: next cycle dn all ones and busy 0, no done pulse, state goes to IDLE, dwell counter clears.
- eneable low -> high: behaviour resumes per mode from entry conditions (scan restarts at idx 0).
- Dwell counter: width $clog2(DWELL+1). Counts 0..DWELL-1. Terminal count advances idx. With DWELL = 1, idx advances every cycle.

## Timing
- Reset values: dn = all ones, idx = 0, busy = 0, done = 0, state IDLE, dwell counter 0.
- Reset has priority over eneable, which has priority over mode and start.
- Direct latency: 1 cycle from a/eneable change to dn.
- Sweep latency: start sampled at edge N -> dn[0] low and busy high after edge N+1.
  - dn[k] low for cycles N+1+k·DWELL .. N+(k+1)·DWELL.
  - done high during cycle N+1+OUTS·DWELL, with dn all ones and busy low in the same cycle.
- Scan: first line low 1 cycle after mode becomes 01; each line low exactly DWELL cycles.
- Reset asserted mid-sweep: outputs take reset values at the next edge; no done pulse.
- Outputs are glitch-free; all are driven directly from flops.
- Never more than one dn bit low in any cycle.

## Structure
- Package deco_pkg: mode_t enum (MODE_DIRECT, MODE_SCAN, MODE_SWEEP, MODE_RSVD), state_t enum (IDLE, DIRECT, SCAN, SWEEP).
- One sub-module, dwell_tick: parametrised DWELL counter with clear and enable inputs and a one-cycle tick output.
- Decode function ~(1 << idx) is inline; it is not a separate module.

## Test plan
- SEL_W=2, direct: eneable=1, a=2 -> dn=4'b1011 one cycle later; a=3 -> 4'b0111; eneable=0 -> 4'b1111.
- SEL_W=2, DWELL=3, scan: mode=01 for 15 cycles -> dn sequence 1110×3, 1101×3, 1011×3, 0111×3, 1110×3.
- SEL_W=2, DWELL=2, sweep: mode=10, start at cycle 0 -> busy cycles 1-8, dn[k] low cycles 1+2k..2+2k, done=1 at cycle 9 only, dn=1111 at cycle 9.
- Sweep abort: eneable=0 at cycle 4 of a DWELL=2 sweep -> dn=1111 and busy=0 from cycle 5, done never asserts; a second start mid-sweep changes nothing.
- Reset mid-scan: reset=1 while dn=1011 -> next cycle dn=1111, idx=0; after release, scan restarts at dn=1110.
- SEL_W=3, DWELL=1, mode=11 with a=5 -> dn=8'b11011111; then mode=01 -> idx 0..7 advancing every cycle, wrapping 7 -> 0.

Source files
------------

// File: rtl/deco_n_neg_scan_pkg.sv
// deco_pkg: shared types for the deco_n_neg_scan decoder.
//   mode_t  - encoding of the 2-bit mode input
//   state_t - controller states (IDLE, DIRECT, SCAN, SWEEP)
package deco_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_SWEEP  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        SWEEP  = 2'd3
    } state_t;

endpackage

// File: rtl/deco_n_neg_scan_dwell_tick.sv
// dwell_tick: counts 0..DWELL-1 while en is high and pulses tick on the
// terminal count. clr (or reset) returns the count to 0.
//   clk   in  clock
//   reset in  synchronous active-high reset
//   clr   in  synchronous clear, priority over en
//   en    in  count enable
//   tick  out high in the cycle the count sits at DWELL-1 with en high
module dwell_tick #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt_reg == LAST);

endmodule

// File: rtl/deco_n_neg_scan.sv
// deco_n_neg_scan: registered SEL_W -> 2**SEL_W active-low one-hot decoder
// with direct, continuous-scan and single-sweep modes.
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   eneable in  enable; low forces all lines inactive and returns to IDLE
//   mode    in  00 direct, 01 scan, 10 sweep, 11 treated as direct
//   a       in  select for direct mode
//   start   in  launches a sweep when mode is 10 and no sweep is running
//   dn      out active-low one-hot strobes (registered)
//   idx     out index of the low line (0 when none)
//   busy    out sweep in progress
//   done    out one-cycle pulse when a sweep completes
module deco_n_neg_scan
    import deco_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eneable,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      a,
    input  logic                  start,
    output logic [(2**SEL_W)-1:0] dn,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  done
);
    localparam int OUTS = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUTS - 1);

    mode_t  mode_in;
    state_t state_reg, state_next, sel_state;

    logic [OUTS-1:0]  dn_reg, line_dec;
    logic [SEL_W-1:0] idx_reg, idx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             lit_next;
    logic             cnt_en, tick;

    assign mode_in = mode_t'(mode);

    always_comb begin
        case (mode_in)
            MODE_SCAN:  sel_state = SCAN;
            MODE_SWEEP: sel_state = IDLE;
            default:    sel_state = DIRECT;
        endcase
    end

    // The dwell counter only runs while a scan or sweep is continuing; any
    // entry, exit or disable leaves it cleared. In the completion cycle of a
    // sweep (done_reg high) a following scan is treated as a fresh entry so
    // line 0 still gets its full dwell.
    assign cnt_en = eneable &&
                    ((state_reg == SWEEP) ||
                     (state_reg == SCAN && !done_reg && mode_in == MODE_SCAN));

    dwell_tick #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk  (clk),
        .reset(reset),
        .clr  (!cnt_en),
        .en   (cnt_en),
        .tick (tick)
    );

    always_comb begin
        state_next = IDLE;
        idx_next   = '0;
        lit_next   = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        if (!eneable) begin
            // defaults: all lines off, IDLE
        end else if (state_reg == SWEEP) begin
            if (tick && idx_reg == LAST_IDX) begin
                done_next  = 1'b1;
                state_next = sel_state;
            end else begin
                state_next = SWEEP;
                busy_next  = 1'b1;
                lit_next   = 1'b1;
                idx_next   = tick ? idx_reg + SEL_W'(1) : idx_reg;
            end
        end else if (mode_in == MODE_SWEEP && start) begin
            state_next = SWEEP;
            busy_next  = 1'b1;
            lit_next   = 1'b1;
        end else begin
            state_next = sel_state;
            case (sel_state)
                SCAN: begin
                    lit_next = 1'b1;
                    // idx wraps OUTS-1 -> 0 through natural overflow
                    if (cnt_en) begin
                        idx_next = tick ? idx_reg + SEL_W'(1) : idx_reg;
                    end
                end
                DIRECT: begin
                    lit_next = 1'b1;
                    idx_next = a;
                end
                default: ;
            endcase
        end
    end

    // Inline active-low decode of the next index.
    for (genvar gi = 0; gi < OUTS; gi++) begin : g_dec
        assign line_dec[gi] = (idx_next != SEL_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            dn_reg    <= '1;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            dn_reg    <= lit_next ? line_dec : '1;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign dn   = dn_reg;
    assign idx  = idx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule
